// File: rtl/logic_shift_unit.sv
// Multi-cycle logic/shift unit: bitwise ops finish in one cycle, shifts and
// rotates step one bit per clock through a work register before reporting.
module logic_shift_unit #(
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done,
  output logic         zf,
  output logic         nf,
  output logic         cf,
  output logic [1:0]   state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [N-1:0]   work_q, work_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;
  logic           zf_q, zf_d, nf_q, nf_d, cf_q, cf_d;

  logic [N-1:0]   logic_r;
  logic [N-1:0]   step_w;
  logic           step_c;
  logic           is_shift;

  always_comb begin
    logic_r = '0;
    case (op)
      3'b000:  logic_r = A & B;
      3'b001:  logic_r = A | B;
      3'b010:  logic_r = A ^ B;
      default: logic_r = A;
    endcase
  end

  assign is_shift = (op == 3'b011) || op[2];

  // One-bit step of the latched operation; step_c is the bit leaving the word.
  always_comb begin
    step_w = work_q;
    step_c = 1'b0;
    case (op_q)
      3'b011: begin step_w = {1'b0, work_q[N-1:1]};        step_c = work_q[0];   end
      3'b100: begin step_w = {work_q[N-2:0], 1'b0};        step_c = work_q[N-1]; end
      3'b101: begin step_w = {work_q[0], work_q[N-1:1]};   step_c = work_q[0];   end
      3'b110: begin step_w = {work_q[N-2:0], work_q[N-1]}; step_c = work_q[N-1]; end
      3'b111: begin step_w = {work_q[N-1], work_q[N-1:1]}; step_c = work_q[0];   end
      default: ;
    endcase
  end

  // Handshake: start is taken only in IDLE (busy=0); busy stays high through
  // the DONE cycle, so the next request can land no earlier than after done.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    cf_d     = cf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          work_d = A;
          cnt_d  = B[SW-1:0];
          if (!is_shift || (B[SW-1:0] == '0)) begin
            state_d  = DONE;
            result_d = logic_r;
            zf_d     = (logic_r == '0);
            nf_d     = logic_r[N-1];
            cf_d     = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_w;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SW'(1)) begin
          state_d  = DONE;
          result_d = step_w;
          zf_d     = (step_w == '0);
          nf_d     = step_w[N-1];
          cf_d     = step_c;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      cf_q     <= cf_d;
    end
  end

  assign result      = result_q;
  assign zf          = zf_q;
  assign nf          = nf_q;
  assign cf          = cf_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign state_dbg_o = state_q;

endmodule
